// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer towards the data memory model (00 idle, 01 busy, 10 done status).
// Sub-word stores are read-modify-write; misaligned/reserved accesses and stuck memory end in resp_err.
//
// state    | meaning
// IDLE     | waiting for a MEM-stage request
// RD_ISSUE | mem_valid high, read waiting for the memory to accept (status 00)
// RD_WAIT  | read in flight, watchdog running
// WR_ISSUE | mem_valid high, write waiting for the memory to accept (status 00)
// WR_WAIT  | write in flight, watchdog running
// DONE     | one-cycle response, pipeline advances
module mem_access_ctrl #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  mem_status
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      WR_ISSUE,
      WR_WAIT,
      DONE
   } state_t;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_DONE = 2'b10;
   localparam logic [7:0] WDOG_LOAD = 8'(TIMEOUT_CYCLES - 1);

   state_t     state;
   logic [7:0] wdog;
   logic       bad_req;

   function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] result;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   result = sgn ? {{24{b[7]}}, b} : {24'b0, b};
         2'b01:   result = sgn ? {{16{h[15]}}, h} : {16'b0, h};
         default: result = word;
      endcase
      return result;
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] data,
                                              input logic [1:0] off, input logic [1:0] size);
      logic [31:0] result;
      result = word;
      if (size == 2'b00)
         result[{off, 3'b000} +: 8] = data[7:0];
      else
         result[{off[1], 4'b0000} +: 16] = data[15:0];
      return result;
   endfunction

   assign bad_req = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);

   assign stall     = req_valid && (state != DONE);
   assign mem_valid = (state == RD_ISSUE) || (state == WR_ISSUE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wdog       <= '0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         mem_addr   <= '0;
         mem_we     <= 1'b0;
         mem_wdata  <= '0;
      end else begin
         // response fields live for the single DONE cycle only
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  mem_addr <= {req_addr[31:2], 2'b00};
                  if (bad_req) begin
                     state      <= DONE;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else if (req_write && req_size == 2'b10) begin
                     mem_we    <= 1'b1;
                     mem_wdata <= req_wdata;
                     state     <= WR_ISSUE;
                  end else begin
                     mem_we <= 1'b0;
                     state  <= RD_ISSUE;
                  end
               end
            end
            RD_ISSUE: begin
               if (mem_status == ST_IDLE) begin
                  wdog  <= WDOG_LOAD;
                  state <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (mem_status == ST_DONE) begin
                  if (req_write) begin
                     mem_wdata <= lane_merge(mem_rdata, req_wdata, req_addr[1:0], req_size);
                     mem_we    <= 1'b1;
                     state     <= WR_ISSUE;
                  end else begin
                     resp_rdata <= lane_extract(mem_rdata, req_addr[1:0], req_size, req_signed);
                     resp_valid <= 1'b1;
                     state      <= DONE;
                  end
               end else if (wdog == 8'd0) begin
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  state      <= DONE;
               end else begin
                  wdog <= wdog - 8'd1;
               end
            end
            WR_ISSUE: begin
               if (mem_status == ST_IDLE) begin
                  wdog  <= WDOG_LOAD;
                  state <= WR_WAIT;
               end
            end
            WR_WAIT: begin
               if (mem_status == ST_DONE) begin
                  resp_valid <= 1'b1;
                  state      <= DONE;
               end else if (wdog == 8'd0) begin
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  state      <= DONE;
               end else begin
                  wdog <= wdog - 8'd1;
               end
            end
            DONE: begin
               mem_we <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized scoreboard bench for mem_access_ctrl with a latency-programmable memory stub
// and a word-array reference model of the load/store semantics.
module tb_mem_access_ctrl;

   localparam int TMO = 16;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
   } txn_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          stall;
   } resp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [1:0]  mem_status;

   txn_t        txn_q[$];
   resp_t       resp_q[$];
   logic [31:0] ref_mem  [bit [31:0]];
   logic [31:0] stub_mem [bit [31:0]];
   int          n_pass = 0;
   int          n_total = 0;
   bit          track = 1'b1;

   mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_status(mem_status)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic fail_note(input string name, input string got, input string need);
      n_total++;
      $display("FAIL %s: got %s required %s", name, got, need);
   endtask

   // Reference semantics: a word array, lanes picked by shifting and masking.
   task automatic model(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int lat);
      resp_t       r;
      txn_t        t;
      bit [31:0]   wa;
      int          off;
      int          bits;
      longint      v;
      longint      mask;
      longint      nw;
      wa = {a[31:2], 2'b00};
      off = int'(a[1:0]);
      r.rdata = '0;
      r.err = 1'b0;
      r.stall = 0;
      if (sz == 2'b11 || (sz == 2'b01 && off % 2 != 0) || (sz == 2'b10 && off != 0)) begin
         r.err = 1'b1;
         r.stall = 1;
      end else if (lat < 0) begin
         r.err = 1'b1;
         r.stall = TMO + 2;
         t = '{we: (wr && sz == 2'b10), addr: wa, wdata: wd, lat: -1};
         txn_q.push_back(t);
      end else begin
         bits = 8 << sz;
         mask = (longint'(1) << bits) - 1;
         if (!wr) begin
            v = (longint'(ref_mem[wa]) >> (8 * off)) & mask;
            if (sg && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
            r.rdata = v[31:0];
            r.stall = lat + 3;
            t = '{we: 1'b0, addr: wa, wdata: 32'h0, lat: lat};
            txn_q.push_back(t);
         end else begin
            nw = (longint'(ref_mem[wa]) & ~(mask << (8 * off))) | ((longint'(wd) & mask) << (8 * off));
            if (sz != 2'b10) begin
               t = '{we: 1'b0, addr: wa, wdata: 32'h0, lat: lat};
               txn_q.push_back(t);
               r.stall = 2 * lat + 5;
            end else begin
               r.stall = lat + 3;
            end
            t = '{we: 1'b1, addr: wa, wdata: nw[31:0], lat: lat};
            txn_q.push_back(t);
            ref_mem[wa] = nw[31:0];
         end
      end
      resp_q.push_back(r);
   endtask

   task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input int lat);
      bit seen;
      model(wr, sz, sg, a, wd, lat);
      req_valid = 1'b1;
      req_write = wr;
      req_size = sz;
      req_signed = sg;
      req_addr = a;
      req_wdata = wd;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) fail_note("resp_timeout", "no resp_valid in 300 cycles", "resp_valid=1");
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Memory stub: accepts on status 00, busy (01) for lat cycles, then done (10) for one cycle.
   initial begin : stub
      int   sst;
      int   cnt;
      bit   moved;
      txn_t cur;
      sst = 0;
      cnt = 0;
      moved = 1'b0;
      cur = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, lat: 0};
      mem_status = 2'b00;
      mem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         if (reset) begin
            sst = 0;
            mem_status <= 2'b00;
            mem_rdata <= $urandom;
         end else begin
            case (sst)
               0: begin
                  mem_rdata <= $urandom;
                  if (mem_valid) begin
                     if (txn_q.size() == 0) begin
                        fail_note("unexpected_mem_access", $sformatf("mem_valid addr 0x%08h", mem_addr), "no access");
                     end else begin
                        cur = txn_q.pop_front();
                        moved = 1'b0;
                        check("accept_we", 32'(mem_we), 32'(cur.we));
                        check("accept_addr", mem_addr, cur.addr);
                        if (cur.lat < 0) begin
                           sst = 3;
                           mem_status <= 2'b01;
                        end else if (cur.lat == 0) begin
                           sst = 2;
                           mem_status <= 2'b10;
                           mem_rdata <= stub_mem[cur.addr];
                        end else begin
                           cnt = cur.lat;
                           sst = 1;
                           mem_status <= 2'b01;
                        end
                     end
                  end
               end
               1: begin
                  mem_rdata <= $urandom;
                  if (mem_addr !== cur.addr || mem_we !== cur.we || (cur.we && mem_wdata !== cur.wdata))
                     moved = 1'b1;
                  if (cnt == 1) begin
                     sst = 2;
                     mem_status <= 2'b10;
                     mem_rdata <= stub_mem[cur.addr];
                  end else begin
                     cnt--;
                  end
               end
               2: begin
                  check("done_addr", mem_addr, cur.addr);
                  check("done_we", 32'(mem_we), 32'(cur.we));
                  check("held_stable", 32'(moved), 32'd0);
                  if (cur.we) begin
                     check("done_wdata", mem_wdata, cur.wdata);
                     stub_mem[cur.addr] = mem_wdata;
                  end
                  sst = 0;
                  mem_status <= 2'b00;
                  mem_rdata <= $urandom;
               end
               default: begin
                  if (resp_valid) begin
                     sst = 0;
                     mem_status <= 2'b00;
                  end
               end
            endcase
         end
      end
   end

   // Monitor: counts stall cycles, pops one expectation per resp_valid.
   initial begin : monitor
      int    stall_cnt;
      resp_t e;
      stall_cnt = 0;
      forever begin
         @(negedge clk);
         if (reset || !track) begin
            stall_cnt = 0;
         end else begin
            if (stall) stall_cnt++;
            if (resp_valid) begin
               if (resp_q.size() == 0) begin
                  fail_note("unexpected_resp", $sformatf("resp_valid rdata 0x%08h", resp_rdata), "no response");
               end else begin
                  e = resp_q.pop_front();
                  check("resp_rdata", resp_rdata, e.rdata);
                  check("resp_err", 32'(resp_err), 32'(e.err));
                  check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                  check("stall_in_done", 32'(stall), 32'd0);
               end
               stall_cnt = 0;
            end
         end
      end
   end

   initial begin : guard
      #1000000;
      $display("FAIL global_timeout: got no finish required finish");
      $fatal(1);
   end

   initial begin : stim
      bit [31:0] a;
      logic [1:0] sz;
      reset = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_size = 2'b00;
      req_signed = 1'b0;
      req_addr = 32'h0;
      req_wdata = 32'h0;
      for (int w = 0; w < 16; w++) begin
         a = 32'h100 + 32'(4 * w);
         ref_mem[a] = $urandom;
         stub_mem[a] = ref_mem[a];
      end
      ref_mem[32'h100] = 32'h8899AABB;
      stub_mem[32'h100] = 32'h8899AABB;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 10);
      do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 3);
      do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0);
      do_req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 2);
      do_req(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000005A, 10);
      do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1);
      do_req(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 4);
      do_req(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 5);
      do_req(1'b1, 2'b10, 1'b0, 32'h102, 32'h12345678, 5);
      do_req(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, TMO - 1);
      do_req(1'b0, 2'b10, 1'b0, 32'h108, 32'h0, -1);
      do_req(1'b1, 2'b01, 1'b0, 32'h10E, 32'hCAFE8001, TMO - 1);
      do_req(1'b0, 2'b01, 1'b1, 32'h10E, 32'h0, 0);

      for (int n = 0; n < 40; n++) begin
         a = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         if (sz == 2'b01 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
         if (sz == 2'b10 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                int'($urandom_range(0, 12)));
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
      end

      // Reset while the read is in RD_WAIT: nothing from that access may surface.
      track = 1'b0;
      txn_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, lat: 10});
      req_valid = 1'b1;
      req_write = 1'b0;
      req_size = 2'b10;
      req_addr = 32'h100;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_stall", 32'(stall), 32'd0);
      check("midrst_mem_valid", 32'(mem_valid), 32'd0);
      check("midrst_resp_valid", 32'(resp_valid), 32'd0);
      check("midrst_mem_addr", mem_addr, 32'd0);
      check("midrst_mem_we", 32'(mem_we), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      txn_q.delete();
      track = 1'b1;
      @(posedge clk);
      #1;
      do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 2);
      do_req(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 1);

      repeat (3) @(posedge clk);
      check("txn_q_drained", 32'(txn_q.size()), 32'd0);
      check("resp_q_drained", 32'(resp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage controller between the pipeline's MEM stage and the data memory model (valid/addr/write_enabled/w_data in; r_data/status out).
- Turns one pipeline load/store into one or two memory transactions over the 00/01/10 status protocol, and stalls the pipeline until the access completes.
- Adds byte/halfword support (lane select, sign/zero extension, read-modify-write stores), misalignment checking and a timeout watchdog.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in any WAIT state before the access is aborted with an error; must fit in 8 bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  MEM stage holds a load/store; held stable while stall=1
- req_write  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- stall  out  1  freeze pipeline
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result, extended; 0 for stores/errors
- resp_err  out  1  valid with resp_valid: misaligned, reserved size or timeout
- mem_valid  out  1  to memory valid
- mem_addr  out  32  to memory addr, always {req_addr[31:2],2'b00}
- mem_we  out  1  to memory write_enabled
- mem_wdata  out  32  to memory w_data
- mem_rdata  in  32  from memory r_data
- mem_status  in  2  from memory status

Behaviour:
- Reset: state IDLE; stall, resp_valid, resp_err, mem_valid, mem_we = 0; resp_rdata, mem_addr, mem_wdata = 0; watchdog = 0.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, DONE.
- stall = req_valid && state!=DONE (combinational). The pipeline advances in the DONE cycle.
- mem_valid = state is RD_ISSUE or WR_ISSUE (combinational). mem_addr, mem_we and mem_wdata are registered and held constant from ISSUE through the end of WAIT, because the memory samples them on its completion edge.
- IDLE + req_valid:
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size 11: go to DONE with err=1. No memory access.
  - Load, or word store: go to RD_ISSUE or WR_ISSUE respectively.
  - Byte/half store: go to RD_ISSUE (read-modify-write).
- ISSUE -> WAIT on an edge where mem_status==00. Otherwise stay in ISSUE.
- RD_WAIT with mem_status==10:
  - Load: capture and extend the selected lane, go to DONE.
  - Sub-word store: merge req_wdata into the captured word, load it into mem_wdata, set mem_we=1, go to WR_ISSUE.
- WR_WAIT with mem_status==10: go to DONE.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. A new request is accepted in the following IDLE cycle; the memory is back at 00 by then.
- Lanes are little-endian:
  - Byte: lane addr[1:0], data bits [8k+7:8k].
  - Half: addr[1]=0 gives [15:0], addr[1]=1 gives [31:16].
  - Sign extension uses the lane MSB.
- Watchdog:
  - Counts cycles in any WAIT state; cleared when entering a WAIT.
  - On reaching TIMEOUT_CYCLES: go to DONE with err=1, drop mem_valid, resp_rdata=0.
- Timing with memory latency L, request first seen at t0:
  - Load or word store: stall high L+3 cycles, resp_valid at t0+L+3.
  - Sub-word store: stall high 2L+5 cycles, resp_valid at t0+2L+5.
- req_valid dropping mid-access is illegal and is not checked. An in-flight transaction always runs to DONE.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. The memory also resets synchronously, so no transaction survives.
- mem_status==10 seen outside a WAIT state is ignored.

Test Plan:
- Word load, addr 0x100 holding 0x8899AABB, L=10 -> stall high 13 cycles; resp_valid one cycle with resp_rdata=0x8899AABB, resp_err=0; mem_addr=0x100 stable throughout.
- Byte loads, addr 0x103 from the same word -> signed gives 0xFFFFFF88, unsigned gives 0x00000088; half signed at 0x102 -> 0xFFFF8899.
- Byte store 0x5A to 0x101 over 0x8899AABB -> one read then one write of 0x88995ABB; stall 25 cycles; a subsequent word load returns 0x88995ABB.
- Word store 0xDEADBEEF to 0x104 -> exactly one write transaction; mem_we=1 and mem_wdata stable until status 10.
- Half load at 0x101, then word store at 0x102 -> each gives resp_err=1 after 1 stall cycle; mem_valid never asserted.
- Reset asserted in RD_WAIT -> next cycle stall=0, mem_valid=0; memory stub held at status 01 with TIMEOUT_CYCLES=4 -> resp_err=1 after 4 WAIT cycles.
